// File: rtl/tile_ram_scheduler.sv
// -----------------------------------------------------------------------------
// tile_ram_scheduler
//
// Owns the single port of the tile name-table RAM (2**ADDR_W x DATA_W,
// address {row,col}, combinational read, synchronous write) and time-shares it
// between three requesters in fixed priority:
//   1. video fetch (vid_active)      - read only, registered into vid_data
//   2. bulk engine (busy)            - fill or increment every entry once
//   3. host valid/ready port         - single-byte reads and writes
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   vid_active/addr     video owns the RAM this cycle / fetch address
//   vid_data            video read data, one cycle after the fetch cycle
//   host_valid/ready    host handshake; ready is independent of valid
//   host_we/addr/wdata  host request (1 = write)
//   host_rvalid/rdata   one-cycle read response, cycle after accept
//   cmd_start/op/value  bulk start pulse, 0 = fill, 1 = increment, fill value
//   busy, done          bulk in progress, one-cycle completion pulse
//   ram_addr/din/we     RAM port
//   ram_dout            RAM combinational read data
// -----------------------------------------------------------------------------
module tile_ram_scheduler #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 8,
   parameter int INC_WRAP = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_active,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              cmd_start,
   input  logic              cmd_op,
   input  logic [DATA_W-1:0] cmd_value,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [DATA_W-1:0] WRAP_VAL  = DATA_W'(INC_WRAP);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              op_q;
   logic [DATA_W-1:0] value_q;

   logic              start_acc;
   logic              bulk_gnt;
   logic              host_acc;
   logic [DATA_W-1:0] inc_val;

   assign busy = (state == RUN);
   assign done = (state == FIN);

   // Host gets the port only when neither video nor the bulk engine wants it.
   // FIN is not busy, so the host is served during the completion cycle.
   assign host_ready = rst && !vid_active && !busy;
   assign host_acc   = host_ready && host_valid;
   assign bulk_gnt   = rst && !vid_active && busy;
   assign start_acc  = (state == IDLE) && cmd_start;

   assign inc_val = (ram_dout == WRAP_VAL) ? '0 : ram_dout + DATA_W'(1);

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; that is what keeps combinational blocks free of latches.
   always_comb begin
      ram_addr  = host_addr;
      ram_din   = host_wdata;
      ram_we    = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;

      // Port mux in priority order. Writes are gated by rst so nothing lands
      // in the table while reset is held, whatever the state register holds.
      if (vid_active) begin
         ram_addr = vid_addr;
      end else if (busy) begin
         ram_addr = cnt;
         ram_din  = op_q ? inc_val : value_q;
         ram_we   = rst;
      end else begin
         ram_we   = host_acc && host_we;
      end

      case (state)
         IDLE: begin
            if (cmd_start) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            // Stalled cycles leave the counter alone, so no entry is skipped.
            // The last entry exits to FIN instead of wrapping the counter.
            if (bulk_gnt) begin
               if (cnt == LAST_ADDR) begin
                  state_nxt = FIN;
               end else begin
                  cnt_nxt = cnt + ADDR_W'(1);
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Operation and fill value are captured once at start; cmd_* may change
   // freely while the engine runs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q    <= 1'b0;
         value_q <= '0;
      end else if (start_acc) begin
         op_q    <= cmd_op;
         value_q <= cmd_value;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vid_data <= '0;
      end else if (vid_active) begin
         vid_data <= ram_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         host_rvalid <= host_acc && !host_we;
         if (host_acc && !host_we) begin
            host_rdata <= ram_dout;
         end
      end
   end

endmodule

// File: tb/tb_tile_ram_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tile_ram_scheduler
//
// Bench for tile_ram_scheduler. Models the external name-table RAM, keeps a
// reference copy of the table, queues expected host and video read data as
// requests are issued, and compares them in a separate monitor when the DUT
// presents host_rvalid or a registered video fetch.
// -----------------------------------------------------------------------------
module tb_tile_ram_scheduler;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int BOUND = 5000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vid_active = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [DW-1:0] vid_data;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          cmd_start = 1'b0;
   logic          cmd_op = 1'b0;
   logic [DW-1:0] cmd_value = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   always #5 clk = ~clk;

   tile_ram_scheduler #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .INC_WRAP (9)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vid_active  (vid_active),
      .vid_addr    (vid_addr),
      .vid_data    (vid_data),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .cmd_start   (cmd_start),
      .cmd_op      (cmd_op),
      .cmd_value   (cmd_value),
      .busy        (busy),
      .done        (done),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_we      (ram_we),
      .ram_dout    (ram_dout)
   );

   // External RAM: combinational read, synchronous write.
   logic [DW-1:0] ram [DEPTH];
   assign ram_dout = ram[ram_addr];
   always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

   // Reference table and scoreboard state.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] rd_q [$];
   logic [DW-1:0] vid_q [$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            done_cnt = 0;
   int            vid_we_err = 0;
   bit            vid_chk_en = 1'b0;
   bit            vid_seen = 1'b0;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] inc_ref(input logic [DW-1:0] v);
      return (v == 8'd9) ? 8'd0 : v + 8'd1;
   endfunction

   // A video fetch is registered at the posedge; its data is compared at the
   // following negedge against the value queued when the fetch was issued.
   always @(posedge clk) vid_seen <= vid_active && vid_chk_en && rst;

   always @(negedge clk) begin
      if (host_rvalid) begin
         if (rd_q.size() == 0) check("rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
         else                  check("host_rdata", {24'd0, host_rdata}, {24'd0, rd_q.pop_front()});
      end
      if (vid_seen) begin
         if (vid_q.size() == 0) check("vid_unexpected", {31'd0, vid_seen}, 32'd0);
         else                   check("vid_data", {24'd0, vid_data}, {24'd0, vid_q.pop_front()});
      end
      if (vid_active && ram_we) vid_we_err++;
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits at negedges until host_ready; reports the number of stalled cycles.
   task automatic wait_ready(input string name, output int waited);
      waited = 0;
      @(negedge clk);
      while (!host_ready && waited < BOUND) begin
         waited++;
         @(negedge clk);
      end
      if (!host_ready) check(name, {31'd0, host_ready}, 32'd1);
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = a;
      host_wdata = d;
      wait_ready("host_write_timeout", waited);
      ref_mem[a] = d;
      tick();
      host_valid = 1'b0;
      host_we    = 1'b0;
   endtask

   task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      int waited;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = a;
      wait_ready("host_read_timeout", waited);
      rd_q.push_back(exp);
      tick();
      host_valid = 1'b0;
   endtask

   task automatic sweep();
      for (int i = 0; i < DEPTH; i++) host_read(AW'(i), ref_mem[i]);
      tick();
      tick();
   endtask

   task automatic start_bulk(input logic op, input logic [DW-1:0] val);
      cmd_start = 1'b1;
      cmd_op    = op;
      cmd_value = val;
      tick();
      cmd_start = 1'b0;
   endtask

   // Runs from just after the start edge until done is seen; cycle 1 is the
   // first cycle after that edge. With alt set, video owns every even cycle.
   task automatic run_bulk(input bit alt, output int cyc);
      cyc = 0;
      forever begin
         cyc++;
         vid_active = alt && (cyc % 2 == 0);
         @(negedge clk);
         if (cyc == 1) check("busy_running", {31'd0, busy}, 32'd1);
         if (done || cyc >= BOUND) break;
         tick();
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
      tick();
      vid_active = 1'b0;
   endtask

   initial begin
      int waited;
      int cyc;
      int dc0;

      // Reset held for two edges with inputs toggling.
      rst        = 1'b0;
      vid_active = 1'b1;
      vid_addr   = 10'h155;
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = 10'h021;
      host_wdata = 8'h5A;
      cmd_start  = 1'b1;
      cmd_op     = 1'b0;
      cmd_value  = 8'hC3;
      tick();
      vid_active = 1'b0;
      host_addr  = 10'h2AA;
      cmd_op     = 1'b1;
      tick();
      check("rst_vid_data",    {24'd0, vid_data},   32'd0);
      check("rst_host_rdata",  {24'd0, host_rdata}, 32'd0);
      check("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
      check("rst_busy",        {31'd0, busy},       32'd0);
      check("rst_done",        {31'd0, done},       32'd0);
      check("rst_ram_we",      {31'd0, ram_we},     32'd0);
      check("rst_host_ready",  {31'd0, host_ready}, 32'd0);
      host_valid = 1'b0;
      host_we    = 1'b0;
      cmd_start  = 1'b0;
      rst        = 1'b1;
      tick();

      // Host write then read back, both accepted without stall.
      host_write(10'h021, 8'h07, waited);
      check("hw_no_stall", waited, 0);
      host_read(10'h021, 8'h07);
      tick();

      // Host write held pending while video owns the port for 5 cycles.
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = 10'h021;
      host_wdata = 8'h3C;
      vid_active = 1'b1;
      vid_addr   = 10'h021;
      vid_chk_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("vid_host_ready", {31'd0, host_ready}, 32'd0);
         check("vid_ram_we",     {31'd0, ram_we},     32'd0);
         vid_q.push_back(8'h07);
         tick();
      end
      vid_active = 1'b0;
      host_write(10'h021, 8'h3C, waited);
      check("pending_lands_first_idle", waited, 0);
      vid_active = 1'b1;
      @(negedge clk);
      vid_q.push_back(8'h3C);
      tick();
      vid_active = 1'b0;
      tick();
      @(negedge clk);
      vid_chk_en = 1'b0;
      check("vid_q_drained", vid_q.size(), 0);
      tick();
      host_read(10'h021, 8'h3C);

      // Preload i mod 10 (0x100 = 0xFF); the last write shares its cycle
      // with cmd_start and must land before the increment pass.
      for (int i = 0; i < DEPTH - 1; i++)
         host_write(AW'(i), (i == 'h100) ? 8'hFF : DW'(i % 10), waited);
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = 10'h3FF;
      host_wdata = 8'h03;
      cmd_start  = 1'b1;
      cmd_op     = 1'b1;
      cmd_value  = 8'h00;
      @(negedge clk);
      check("start_cycle_host_ready", {31'd0, host_ready}, 32'd1);
      ref_mem[DEPTH-1] = 8'h03;
      tick();
      host_valid = 1'b0;
      host_we    = 1'b0;
      cmd_start  = 1'b0;
      dc0 = done_cnt;
      run_bulk(1'b0, cyc);
      check("inc_cycles", cyc, 1025);
      tick();
      check("inc_done_once", done_cnt - dc0, 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = inc_ref(ref_mem[i]);
      host_read(10'h009, 8'h00);
      host_read(10'h00A, 8'h01);
      host_read(10'h3FF, 8'h04);
      host_read(10'h100, 8'h00);
      host_read(10'h00B, 8'h02);
      sweep();

      // Fill 0xAA with video taking every other cycle.
      vid_addr = 10'h000;
      start_bulk(1'b0, 8'hAA);
      run_bulk(1'b1, cyc);
      check("fill_alt_cycles", cyc, 2048);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hAA;
      sweep();
      check("no_write_on_video", vid_we_err, 0);

      // Fill 0x55, ignored restart, then reset once counter reaches 0x200.
      dc0 = done_cnt;
      start_bulk(1'b0, 8'h55);
      cmd_start = 1'b1;
      cmd_op    = 1'b1;
      cmd_value = 8'h11;
      tick();
      cmd_start = 1'b0;
      for (int i = 0; i < 511; i++) tick();
      check("busy_before_abort", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      tick();
      for (int i = 0; i < 10; i++) tick();
      check("abort_no_done", done_cnt - dc0, 0);
      for (int i = 0; i < DEPTH / 2; i++) ref_mem[i] = 8'h55;
      host_read(10'h1FF, 8'h55);
      host_read(10'h200, 8'hAA);
      sweep();

      check("rd_q_drained", rd_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
